port_write_scheduler: RTL



---
 rtl/port_map_pkg.sv | 28 ++
 rtl/port_write_scheduler_if.sv | 29 ++
 rtl/port_write_scheduler_rr_arbiter.sv | 47 ++++
 rtl/port_write_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/port_map_pkg.sv
`default_nettype none
// ============================================================================
// Package  : port_map_pkg
// Desc     : Control-register port map, button codes and scheduler FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package port_map_pkg;

    localparam logic [7:0] PORT_SW    = 8'h01;
    localparam logic [7:0] PORT_CTRL  = 8'h10;
    localparam logic [7:0] PORT_CRONO = 8'h11;
    localparam logic [7:0] PORT_AA    = 8'h20;
    localparam logic [7:0] PORT_FH    = 8'h21;
    localparam logic [7:0] PORT_BTN   = 8'h22;

    localparam logic [7:0] BTN_CODE_1 = 8'h01;
    localparam logic [7:0] BTN_CODE_2 = 8'h02;
    localparam logic [7:0] BTN_CODE_3 = 8'h03;
    localparam logic [7:0] BTN_CODE_4 = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/port_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : port_write_scheduler_if
// Desc      : Requester handshake plus the shared processor-style write bus.
// Revision  : 1.0 - initial release
// ============================================================================
interface port_write_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_port;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [7:0]        port_id;
    logic [7:0]        out_port;
    logic              en_10;
    logic              busy;

    modport master (
        output req, req_port, req_data,
        input  ack, port_id, out_port, en_10, busy
    );

    modport slave (
        input  req, req_port, req_data,
        output ack, port_id, out_port, en_10, busy
    );
endinterface
`default_nettype wire

// File: rtl/port_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin grant over NREQ levels; pointer moves past the winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic             adv_i,
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((32'(rr_ptr_q) + 32'(k)) % 32'(NREQ));
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o     = 1'b1;
                gnt_idx_o     = idx;
                gnt_oh_o[idx] = 1'b1;
            end
        end
    end

    assign rr_ptr_d = (gnt_idx_o == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (adv_i) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/port_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : port_write_scheduler
// Desc     : Shares the port write bus among NREQ requesters, auto-clears buttons.
//            Build option SCHED_DBG_EN adds dbg_wr_count / dbg_last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module port_write_scheduler
    import port_map_pkg::*;
#(
    parameter int         NREQ     = 4,
    parameter int         GAP_CYC  = 1,
    parameter int         HOLD_CYC = 16,
    parameter logic [7:0] BTN_PORT = PORT_BTN
) (
    input  logic                  reloj,
    input  logic                  resetM,
    port_write_scheduler_if.slave bus
`ifdef SCHED_DBG_EN
    ,
    output logic [15:0]           dbg_wr_count,
    output logic [3:0]            dbg_last_grant
`endif
);
    localparam int          IDX_W     = $clog2(NREQ);
    localparam logic [3:0]  GAP_LOAD  = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;
    // The strobe cycle itself is the first hold cycle, so the clear lands HOLD_CYC after it.
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);

    sched_state_e     state_q, state_d;
    logic [7:0]       port_id_q, port_id_d;
    logic [7:0]       out_port_q, out_port_d;
    logic             en_10_q, en_10_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [3:0]       gap_q, gap_d;
    logic [15:0]      hold_q, hold_d;
    logic             pend_q, pend_d;

    logic             clear_due;
    logic             adv;
    logic             clr_sel;
    logic [NREQ-1:0]  gnt_oh;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [7:0]       sel_port;
    logic [7:0]       sel_data;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (reloj),
        .rst       (resetM),
        .req_i     (bus.req),
        .adv_i     (adv),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign clear_due = pend_q && (hold_q == 16'd0);
    assign sel_port  = bus.req_port[{gnt_idx, 3'b000} +: 8];
    assign sel_data  = bus.req_data[{gnt_idx, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        port_id_d  = port_id_q;
        out_port_d = out_port_q;
        en_10_d    = 1'b0;
        ack_d      = '0;
        gap_d      = gap_q;
        pend_d     = pend_q;
        hold_d     = (hold_q != 16'd0) ? hold_q - 16'd1 : hold_q;
        adv        = 1'b0;
        clr_sel    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_due) begin
                    state_d    = ST_WR;
                    port_id_d  = BTN_PORT;
                    out_port_d = 8'h00;
                    en_10_d    = 1'b1;
                    pend_d     = 1'b0;
                    clr_sel    = 1'b1;
                end else if (gnt_vld) begin
                    state_d    = ST_WR;
                    port_id_d  = sel_port;
                    out_port_d = sel_data;
                    en_10_d    = 1'b1;
                    ack_d      = gnt_oh;
                    adv        = 1'b1;
                    // A zero button write from a requester releases the button itself.
                    if (sel_port == BTN_PORT) begin
                        pend_d = (sel_data != 8'h00);
                        if (sel_data != 8'h00) begin
                            hold_d = HOLD_LOAD;
                        end
                    end
                end
            end
            ST_WR: begin
                if (GAP_CYC > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || pend_d;
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q    <= ST_IDLE;
            port_id_q  <= 8'h00;
            out_port_q <= 8'h00;
            en_10_q    <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            gap_q      <= 4'd0;
            hold_q     <= 16'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_id_q  <= port_id_d;
            out_port_q <= out_port_d;
            en_10_q    <= en_10_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.port_id  = port_id_q;
    assign bus.out_port = out_port_q;
    assign bus.en_10    = en_10_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;

`ifdef SCHED_DBG_EN
    logic [15:0] dbg_cnt_q;
    logic [3:0]  dbg_last_q;

    always_ff @(posedge reloj) begin
        if (resetM) begin
            dbg_cnt_q  <= 16'd0;
            dbg_last_q <= 4'd0;
        end else if (en_10_d) begin
            if (dbg_cnt_q != 16'hFFFF) begin
                dbg_cnt_q <= dbg_cnt_q + 16'd1;
            end
            dbg_last_q <= clr_sel ? 4'hF : 4'(gnt_idx);
        end
    end

    assign dbg_wr_count   = dbg_cnt_q;
    assign dbg_last_grant = dbg_last_q;
`endif
endmodule
`default_nettype wire
